// File: rtl/hs4_pkg.sv
// Shared types and default sizes for the hs4 four-phase handshake receiver.
package hs4_pkg;

    localparam int unsigned HS4_DATA_W      = 4;
    localparam int unsigned HS4_DEPTH       = 4;
    localparam int unsigned HS4_SYNC_STAGES = 2;

    // DISARM blocks capture of a request that was already high when reset released.
    typedef enum logic [1:0] {
        DISARM = 2'd0,
        IDLE   = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } hs4_state_t;

    // Occupancy counter width for a FIFO of the given depth (holds 0..depth).
    function automatic int unsigned hs4_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hs4_receiver_if.sv
// Sender handshake and consumer read port of the hs4 receiver, bundled as one interface.
interface hs4_receiver_if #(
    parameter int unsigned DATA_W = hs4_pkg::HS4_DATA_W,
    parameter int unsigned DEPTH  = hs4_pkg::HS4_DEPTH
);
    localparam int unsigned CNT_W = hs4_pkg::hs4_cnt_w(DEPTH);

    logic              send;
    logic [DATA_W-1:0] data;
    logic              ack;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              valid;
    logic              full;
    logic [CNT_W-1:0]  count;

    // Sender plus consumer side.
    modport master (
        output send, data, rd_en,
        input  ack, rd_data, valid, full, count
    );

    // Receiver side.
    modport slave (
        input  send, data, rd_en,
        output ack, rd_data, valid, full, count
    );

endinterface

// File: rtl/hs4_rx_fifo.sv
// Show-ahead FIFO buffering captured handshake words for the local consumer.
module hs4_rx_fifo
    import hs4_pkg::*;
#(
    parameter int unsigned DATA_W = HS4_DATA_W,
    parameter int unsigned DEPTH  = HS4_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             rd_en,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             valid,
    output logic                             full,
    output logic [hs4_cnt_w(DEPTH)-1:0]      count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = hs4_cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              valid_q, valid_d;
    logic              do_wr_c;
    logic              do_rd_c;

    // Pointer, occupancy and flag next-state; pop on empty is dropped.
    always_comb begin
        do_wr_c  = wr_en && !full_q;
        do_rd_c  = rd_en && valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr_c) begin
            wr_ptr_d = AW'(wr_ptr_q + AW'(1));
        end
        if (do_rd_c) begin
            rd_ptr_d = AW'(rd_ptr_q + AW'(1));
        end
        if (do_wr_c && !do_rd_c) begin
            count_d = CNT_W'(count_q + CNT_W'(1));
        end else if (!do_wr_c && do_rd_c) begin
            count_d = CNT_W'(count_q - CNT_W'(1));
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        valid_d = (count_d != CNT_W'(0));
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = valid_q ? mem_q[rd_ptr_q] : '0;
    assign valid   = valid_q;
    assign full    = full_q;
    assign count   = count_q;

endmodule

// File: rtl/hs4_receiver.sv
// Receiving end of the 4-bit send/ack four-phase handshake with a buffering FIFO.
module hs4_receiver
    import hs4_pkg::*;
#(
    parameter int unsigned DATA_W      = HS4_DATA_W,
    parameter int unsigned DEPTH       = HS4_DEPTH,
    parameter int unsigned SYNC_STAGES = HS4_SYNC_STAGES
) (
    input logic           clk,
    input logic           rst,
    hs4_receiver_if.slave bus
);

    localparam int unsigned CNT_W = hs4_cnt_w(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] prime_q, prime_d;
    hs4_state_t             state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   send_s_c;
    logic                   primed_c;
    logic                   wr_en_c;
    logic                   fifo_full;
    logic                   fifo_valid;
    logic [DATA_W-1:0]      fifo_rd_data;
    logic [CNT_W-1:0]       fifo_count;

    // Synchroniser shift plus a primer that marks when send_s reflects the real input.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], bus.send};
        prime_d  = {prime_q[SYNC_STAGES-2:0], 1'b1};
        send_s_c = sync_q[SYNC_STAGES-1];
        primed_c = prime_q[SYNC_STAGES-1];
    end

    // Handshake FSM next-state, write strobe and ack decode.
    always_comb begin
        state_d = state_q;
        wr_en_c = 1'b0;
        unique case (state_q)
            DISARM: begin
                if (primed_c && !send_s_c) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (send_s_c) begin
                    if (!fifo_full) begin
                        wr_en_c = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!fifo_full) begin
                    wr_en_c = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!send_s_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = DISARM;
        endcase
        ack_d = (state_q == ACK);
    end

    // State, synchroniser and ack registers; reset drops ack at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            prime_q <= '0;
            state_q <= DISARM;
            ack_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prime_q <= prime_d;
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    hs4_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_data (bus.data),
        .rd_en   (bus.rd_en),
        .rd_data (fifo_rd_data),
        .valid   (fifo_valid),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign bus.ack     = ack_q;
    assign bus.rd_data = fifo_rd_data;
    assign bus.valid   = fifo_valid;
    assign bus.full    = fifo_full;
    assign bus.count   = fifo_count;

endmodule

// File: tb/tb_hs4_receiver.sv
// Scoreboard bench for hs4_receiver: senders push expected words, a monitor checks every pop.
module tb_hs4_receiver;

    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SS    = 2;

    logic clk  = 1'b0;
    logic sclk = 1'b0;
    logic rst  = 1'b0;
    int   rhalf = 5;
    int   shalf = 16;

    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] expq [$];
    logic pop_req  = 1'b0;
    logic rand_pop = 1'b0;
    logic done5    = 1'b0;

    always #(rhalf) clk  = ~clk;
    always #(shalf) sclk = ~sclk;

    hs4_receiver_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    hs4_receiver #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Consumer: rd_en changes just after the receiver edge.
    initial begin
        bus.rd_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rd_en = rand_pop ? ($urandom_range(0, 1) == 1) : pop_req;
        end
    end

    // Monitor: every accepted pop must match the oldest expected word.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst && bus.rd_en && bus.valid) begin
                if (expq.size() == 0) begin
                    chk("pop_unexpected", int'(bus.rd_data), -1);
                end else begin
                    e = expq.pop_front();
                    chk("pop_data", int'(bus.rd_data), int'(e));
                end
            end
        end
    end

    task automatic wait_rx(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sender clocked by the receiver clock (directed tests).
    task automatic xfer(input logic [DW-1:0] d);
        int n;
        @(negedge clk);
        bus.data = d;
        bus.send = 1'b1;
        expq.push_back(d);
        n = 0;
        while (!bus.ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_ack_rise", int'(bus.ack), 1);
        bus.send = 1'b0;
        n = 0;
        while (bus.ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_ack_fall", int'(bus.ack), 0);
    endtask

    // Sender on its own asynchronous clock.
    task automatic xfer_s(input logic [DW-1:0] d);
        int n;
        @(posedge sclk);
        #1;
        bus.data = d;
        bus.send = 1'b1;
        expq.push_back(d);
        n = 0;
        while (!bus.ack && n < 200) begin
            @(posedge sclk);
            #1;
            n++;
        end
        chk("async_ack_rise", int'(bus.ack), 1);
        @(posedge sclk);
        #1;
        bus.send = 1'b0;
        n = 0;
        while (bus.ack && n < 200) begin
            @(posedge sclk);
            #1;
            n++;
        end
        chk("async_ack_fall", int'(bus.ack), 0);
    endtask

    // Pop everything, then the FIFO and the scoreboard must both be empty.
    task automatic drain();
        int n;
        n = 0;
        pop_req = 1'b1;
        while (bus.valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        pop_req = 1'b0;
        wait_rx(3);
        chk("drain_valid", int'(bus.valid), 0);
        chk("drain_count", int'(bus.count), 0);
        chk("drain_sb_left", expq.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        bus.send = 1'b0;
        bus.data = '0;

        // 1: reset values
        wait_rx(3);
        rst = 1'b1;
        chk("rst_ack", int'(bus.ack), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_rd_data", int'(bus.rd_data), 0);
        wait_rx(5);

        // 2: single transfer, ack latency and release
        @(negedge clk);
        bus.data = 4'hA;
        bus.send = 1'b1;
        expq.push_back(4'hA);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.ack && lat < 10);
        chk("ack_latency_in_range", int'(lat >= int'(SS) + 1 && lat <= int'(SS) + 2), 1);
        @(negedge clk);
        bus.send = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_held_after_drop", int'(bus.ack), 1);
        n = 0;
        while (bus.ack && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ack_released", int'(bus.ack), 0);
        @(negedge clk);
        chk("t2_count", int'(bus.count), 1);
        chk("t2_rd_data", int'(bus.rd_data), 'hA);
        chk("t2_valid", int'(bus.valid), 1);
        drain();

        // 3: fill, stall the 5th request, release it with one pop
        for (int i = 1; i <= 4; i++) begin
            xfer(4'(i));
        end
        chk("t3_full", int'(bus.full), 1);
        chk("t3_count", int'(bus.count), 4);
        fork
            begin
                xfer(4'h5);
                done5 = 1'b1;
            end
        join_none
        wait_rx(12);
        chk("t3_wait_no_ack", int'(bus.ack), 0);
        chk("t3_wait_count", int'(bus.count), 4);
        pop_req = 1'b1;
        @(negedge clk);
        pop_req = 1'b0;
        n = 0;
        while (!done5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("t3_fifth_acked", int'(done5), 1);
        chk("t3_count_after", int'(bus.count), 4);
        drain();

        // 4: pop in the capture cycle with two words queued
        xfer(4'h8);
        xfer(4'h9);
        chk("t4_count_pre", int'(bus.count), 2);
        @(negedge clk);
        bus.data = 4'hB;
        bus.send = 1'b1;
        expq.push_back(4'hB);
        @(negedge clk);
        pop_req = 1'b1;
        @(negedge clk);
        pop_req = 1'b0;
        @(negedge clk);
        chk("t4_count_same", int'(bus.count), 2);
        n = 0;
        while (!bus.ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_ack", int'(bus.ack), 1);
        bus.send = 1'b0;
        wait_rx(6);
        drain();

        // 5: reset during ACK with send held high
        @(negedge clk);
        bus.data = 4'h3;
        bus.send = 1'b1;
        expq.push_back(4'h3);
        n = 0;
        while (!bus.ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_ack_before_rst", int'(bus.ack), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_ack_drop", int'(bus.ack), 0);
        chk("t5_count_rst", int'(bus.count), 0);
        expq.delete();
        wait_rx(3);
        rst = 1'b1;
        wait_rx(10);
        chk("t5_no_dup_ack", int'(bus.ack), 0);
        chk("t5_no_dup_capture", int'(bus.count), 0);
        bus.send = 1'b0;
        wait_rx(6);
        xfer(4'h7);
        chk("t5_one_capture", int'(bus.count), 1);
        chk("t5_rd_data", int'(bus.rd_data), 7);
        drain();

        // 6a: sender 32 ns period, receiver 10 ns, random pops
        rand_pop = 1'b1;
        for (int i = 0; i < 200; i++) begin
            xfer_s(4'($urandom_range(0, 15)));
        end
        rand_pop = 1'b0;
        wait_rx(4);
        drain();

        // 6b: sender 10 ns period, receiver 32 ns
        rhalf = 16;
        shalf = 5;
        wait_rx(4);
        rand_pop = 1'b1;
        for (int i = 0; i < 200; i++) begin
            xfer_s(4'($urandom_range(0, 15)));
        end
        rand_pop = 1'b0;
        wait_rx(4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
